// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic cell that the
// serial adder reuses for every bit position.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    logic w_p;

    // Propagate term shared by the sum and the carry.
    assign w_p     = i_a ^ i_b;
    assign o_sum   = w_p ^ i_cin;
    assign o_carry = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: operands are captured on an accepted start, added
// LSB-first one bit per clock through one full-adder cell, and the registered
// sum/carry-out are published with a one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds the i_sub port (A-B mode).
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit processed per cycle, busy=1
// DONE  | one-cycle result pulse, start accepted here too
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic             w_load;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;
    logic             w_s;
    logic             w_c;

    // Subtraction is A + ~B + 1, so the loaded B and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load     = i_sub ? ~i_b : i_b;
    assign w_carry_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load     = i_b;
    assign w_carry_load = i_cin;
`endif

    serial_fa_cell u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_cin   (r_carry),
        .o_sum   (w_s),
        .o_carry (w_c)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs, all derived from registered state.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_done = (r_state == DONE);
                if (i_start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand shifting, carry chain and result capture on the last bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a_sh   <= i_a;
            r_b_sh   <= w_b_load;
            r_sum_sh <= '0;
            r_carry  <= w_carry_load;
            r_cnt    <= CNT_LAST;
        end else if (w_busy) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_carry  <= w_c;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

    assign o_busy = w_busy;
    assign o_done = w_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized
// operands checked against plain-arithmetic expected results.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp;
    int n_err;

    logic [W-1:0] held_sum;
    logic         held_cout;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one operation in the current cycle, checks every busy cycle,
    // and returns in the done cycle after checking the result. A nonzero
    // glitch pulses start (with glitch_a on A) during that busy cycle.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input logic op_sub,
                          input int glitch, input logic [W-1:0] glitch_a);
        logic [W:0] exp_v;
        if (op_sub)
            exp_v = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
        else
            exp_v = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin);
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = op_sub;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            chk("busy_run", 64'(busy), 64'(1));
            chk("done_early", 64'(done), 64'(0));
            chk("sum_held", 64'(sum), 64'(held_sum));
            chk("cout_held", 64'(cout), 64'(held_cout));
            if (i == glitch) begin
                start = 1'b1;
                a     = glitch_a;
                b     = W'($urandom);
                cin   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("sum", 64'(sum), 64'(exp_v[W-1:0]));
        chk("cout", 64'(cout), 64'(exp_v[W]));
        held_sum  = exp_v[W-1:0];
        held_cout = exp_v[W];
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_cmp     = 0;
        n_err     = 0;
        held_sum  = '0;
        held_cout = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        rst = 1'b0;
        tick();

        // Full carry ripple: FF + 01.
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, '0);
        tick();
        chk("done_single", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Carry-in used.
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 0, '0);
        tick();

        // Start during busy is ignored.
        run_op(8'h10, 8'h10, 1'b0, 1'b0, 3, 8'hFF);
        tick();
        chk("one_done", 64'(done), 64'(0));
        chk("glitch_idle", 64'(busy), 64'(0));

        // Reset in cycle 4 of an operation aborts it.
        a     = 8'h33;
        b     = 8'h44;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        held_sum  = '0;
        held_cout = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
            chk("abort_no_busy", 64'(busy), 64'(0));
        end

        // Back-to-back: second start on the done cycle.
        run_op(8'hC3, 8'h7E, 1'b1, 1'b0, 0, '0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, '0);
        tick();
        chk("b2b_no_double", 64'(done), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, '0);
        tick();
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, '0);
        tick();
`endif

        // Randomized operations, randomly chained back-to-back.
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            run_op(ra, rb, 1'($urandom), 1'($urandom), 0, '0);
`else
            run_op(ra, rb, 1'($urandom), 1'b0, 0, '0);
`endif
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk("rand_no_double", 64'(done), 64'(0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
